// File: rtl/debug_dump.sv
// Dumps a 21-byte debug frame over UART when the CPU halts: a sync byte,
// four register-file bytes, then sixteen data-memory bytes.
module debug_dump #(
    parameter int         CLKS_PER_BIT = 434,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       stopped,
    input  logic [7:0] read_data,
    output logic       is_dm_access,
    output logic [3:0] read_addr,
    output logic       tx,
    output logic       busy,
    output logic       done
);
    localparam int              BAUD_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [4:0]      LAST_INDEX = 5'd20;
    localparam logic [3:0]      STOP_BIT   = 4'd9;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_LOAD,
        S_SEND,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic              r_stopped_d;
    logic [4:0]        r_index;
    logic [3:0]        r_bit_cnt;
    logic [BAUD_W-1:0] r_baud_cnt;
    logic [7:0]        r_shift;
    logic              r_tx;
    logic              r_busy;
    logic              r_done;
    logic              r_is_dm;
    logic [3:0]        r_addr;

    logic              w_trigger;
    logic              w_baud_end;
    logic              w_byte_end;
    logic              w_enter_setup;
    logic [4:0]        w_index_next;
    logic              w_dm_next;
    logic [3:0]        w_addr_next;

    assign w_trigger     = stopped & ~r_stopped_d;
    assign w_baud_end    = (r_baud_cnt == BAUD_LAST);
    assign w_byte_end    = w_baud_end && (r_bit_cnt == STOP_BIT);
    assign w_enter_setup = (w_state_next == S_SETUP);

    // Address for the byte about to be set up; it is presented during SETUP so
    // that read_data is valid by the LOAD cycle.
    always_comb begin
        w_index_next = (r_state == S_IDLE) ? 5'd0 : r_index + 5'd1;
        w_dm_next    = 1'b0;
        w_addr_next  = 4'd0;
        if (w_index_next >= 5'd5) begin
            w_dm_next   = 1'b1;
            w_addr_next = 4'(w_index_next - 5'd5);
        end else if (w_index_next != 5'd0) begin
            w_addr_next = 4'(w_index_next - 5'd1);
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_trigger) w_state_next = S_SETUP;
            S_SETUP: w_state_next = S_LOAD;
            S_LOAD:  w_state_next = S_SEND;
            S_SEND: begin
                if (w_byte_end)
                    w_state_next = (r_index == LAST_INDEX) ? S_DONE : S_SETUP;
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stopped_d <= 1'b0;
            r_index     <= 5'd0;
            r_bit_cnt   <= 4'd0;
            r_baud_cnt  <= '0;
            r_shift     <= 8'd0;
            r_tx        <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_is_dm     <= 1'b0;
            r_addr      <= 4'd0;
        end else begin
            r_stopped_d <= stopped;
            if (w_enter_setup) begin
                r_index <= w_index_next;
                r_is_dm <= w_dm_next;
                r_addr  <= w_addr_next;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_trigger) begin
                        r_busy <= 1'b1;
                        r_done <= 1'b0;
                    end
                end
                S_LOAD: begin
                    r_shift    <= (r_index == 5'd0) ? SYNC_BYTE : read_data;
                    r_tx       <= 1'b0;
                    r_bit_cnt  <= 4'd0;
                    r_baud_cnt <= '0;
                end
                S_SEND: begin
                    if (w_baud_end) begin
                        r_baud_cnt <= '0;
                        // Shifting ones in leaves a 1 at bit 0 for the stop bit.
                        if (r_bit_cnt != STOP_BIT) begin
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                            r_tx      <= r_shift[0];
                            r_shift   <= {1'b1, r_shift[7:1]};
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_index <= 5'd0;
                    r_is_dm <= 1'b0;
                    r_addr  <= 4'd0;
                end
                default: ;
            endcase
        end
    end

    assign tx           = r_tx;
    assign busy         = r_busy;
    assign done         = r_done;
    assign is_dm_access = r_is_dm;
    assign read_addr    = r_addr;
endmodule

// File: doc/debug_dump.md
DEBUG_DUMP -- requirements
Module: debug_dump

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, sets clock cycles per UART bit (50 MHz / 115200).
REQ-002 Parameter SYNC_BYTE, default 8'hA5, is the frame header byte.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 stopped  input  1  CPU halted flag, synchronous to clk.
REQ-006 read_data  input  8  debug read data; valid one cycle after read_addr/is_dm_access change.
REQ-007 is_dm_access  output  1  0 selects register file, 1 selects data memory.
REQ-008 read_addr  output  4  debug read address; RF uses bits [1:0].
REQ-009 tx  output  1  UART serial out, idle high.
REQ-010 busy  output  1  high while a frame is being dumped.
REQ-011 done  output  1  high after a frame completes, until next trigger or reset.

Function
REQ-012 Trigger SHALL be a rising edge of stopped, detected against a registered copy of stopped.
REQ-013 Frame SHALL be 21 bytes in order: SYNC_BYTE, RF[0..3], DM[0..15].
REQ-014 States SHALL be IDLE, SETUP, LOAD, SEND, DONE.
REQ-015 IDLE: on trigger -> SETUP with byte index 0; busy=1 and done=0 from the next cycle.
REQ-016 SETUP: one cycle; drive read_addr and is_dm_access for the current index (index 1-4: is_dm_access=0, read_addr=index-1; index 5-20: is_dm_access=1, read_addr=index-5; index 0: both 0).
REQ-017 LOAD: one cycle; capture SYNC_BYTE (index 0) or read_data into the shift register; -> SEND.
REQ-018 SEND: start bit (0), 8 data bits LSB first, stop bit (1), each exactly CLKS_PER_BIT cycles; 10*CLKS_PER_BIT cycles total.
REQ-019 After the stop bit: if index < 20, increment the index and go to SETUP; otherwise go to DONE.
REQ-020 Gap between a stop bit end and the next start bit SHALL be exactly 2 cycles of tx=1 (SETUP, LOAD).
REQ-021 DONE: one cycle, then IDLE with busy=0 and done=1.
REQ-022 A trigger edge while busy SHALL be ignored; it SHALL NOT restart or queue a frame.
REQ-023 stopped falling mid-frame SHALL NOT abort the frame.
REQ-024 read_addr and is_dm_access SHALL hold their values outside SETUP; in IDLE both SHALL be 0.
REQ-025 Bit counter, baud counter and byte index SHALL be sized for their maximum values with no wrap during a frame; byte index maximum is 20.
REQ-026 tx SHALL be registered; it SHALL have no combinational path from inputs.

Reset
REQ-027 While rst=1, all state SHALL be forced immediately, independent of clk: state=IDLE, tx=1, busy=0, done=0, read_addr=0, is_dm_access=0, counters=0, stopped history=0.
REQ-028 If stopped=1 when rst releases, the stopped history is 0, so that level SHALL count as a rising edge on the first clock after reset.
REQ-029 rst asserted mid-byte SHALL truncate the frame; tx SHALL return high asynchronously, and the frame SHALL NOT resume after release.

Verification (bench uses CLKS_PER_BIT=4)
REQ-030 RF={11,22,33,44}, DM[i]=8'h80+i; raise stopped -> UART decoder receives A5,11,22,33,44,80..8F; then busy=0, done=1.
REQ-031 Trigger, then count cycles from the first start bit to the final stop-bit end -> 21*40 + 20*2 = 880 cycles; each inter-byte gap is exactly 2 cycles.
REQ-032 Drop stopped and raise it again during byte 3 -> a single 21-byte frame only; the second edge is ignored.
REQ-033 Assert rst during the data bits of byte 5 -> tx=1, busy=0 and done=0 immediately; no further bytes; the next trigger sends a complete new frame starting with A5.
REQ-034 Hold stopped=1 through reset release -> frame starts on the first clock after release.
REQ-035 Monitor during the frame -> read_addr/is_dm_access sequence (0,0),(0,0..3),(1,0..15), each held stable through its LOAD cycle.
